// File: rtl/max10nios_pkg.sv
// -----------------------------------------------------------------------------
// max10nios_pkg
// Shared definitions for the MAX10 Nios busy poller:
//   - poll_state_e : controller state encoding (IDLE, READ, WAIT_DATA, GAP)
//   - AVM_ADDR_W / AVM_DATA_W : Avalon-MM master address / data widths
//   - STATUS_ADDR : address of the busy status word (always 0)
//   - sat_inc16() : 16-bit saturating increment used by the poll counter
// -----------------------------------------------------------------------------
package max10nios_pkg;

  localparam int AVM_ADDR_W = 2;
  localparam int AVM_DATA_W = 32;

  localparam logic [AVM_ADDR_W-1:0] STATUS_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_GAP       = 2'd3
  } poll_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/max10nios_gap_timer.sv
// -----------------------------------------------------------------------------
// max10nios_gap_timer
// 16-bit loadable down-counter with zero flag. Times the idle gap between
// consecutive status polls.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset (count forced to 0)
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one (holds at zero)
//   zero_o     - count is zero
// -----------------------------------------------------------------------------
module max10nios_gap_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 16'd0)) begin
      count_d = count_q - 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/max10nios_busy_poller.sv
// -----------------------------------------------------------------------------
// max10nios_busy_poller
// Avalon-MM read initiator that polls the busy bit of a status word until it
// clears, with a fixed idle gap between polls and an optional poll limit.
//
// Parameters:
//   POLL_GAP  - idle cycles between polls (1..65535)
//   MAX_POLLS - poll limit before timeout (1..65535), timeout build only
//   BUSY_BIT  - bit index of the busy flag within avm_readdata (0..31)
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - one-cycle request; honoured only in IDLE
//   done                - one-cycle pulse: busy observed clear
//   timed_out           - one-cycle pulse: MAX_POLLS reads all busy
//   active              - high in every state except IDLE
//   poll_count          - reads issued in the current/last operation
//   avm_address/avm_read/avm_waitrequest/avm_readdata - Avalon-MM master
//
// Build option: define MAX10NIOS_BUSY_POLLER_TIMEOUT_EN to enable the
// MAX_POLLS timeout; without it polling continues until busy clears and
// timed_out stays 0.
// -----------------------------------------------------------------------------
module max10nios_busy_poller
  import max10nios_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024,
  parameter int unsigned BUSY_BIT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic                  timed_out,
  output logic                  active,
  output logic [15:0]           poll_count,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata
);

  poll_state_e state_q, state_d;
  logic [15:0] poll_count_q, poll_count_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic        active_q, active_d;
  logic        avm_read_q, avm_read_d;

  logic        gap_load_s;
  logic        gap_dec_s;
  logic        gap_zero_s;
  logic        busy_s;

  assign busy_s = avm_readdata[BUSY_BIT];

  max10nios_gap_timer u_gap_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (gap_load_s),
    .load_val_i (16'(POLL_GAP - 1)),
    .dec_i      (gap_dec_s),
    .zero_o     (gap_zero_s)
  );

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d      = state_q;
    poll_count_d = poll_count_q;
    done_d       = 1'b0;
    timed_out_d  = 1'b0;
    gap_load_s   = 1'b0;
    gap_dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done/timed_out pulse is dropped so the
        // caller sees the pulse before a new operation can begin.
        if (start && !done_q && !timed_out_q) begin
          state_d      = ST_READ;
          poll_count_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!avm_waitrequest) begin
          poll_count_d = sat_inc16(poll_count_q);
          state_d      = ST_WAIT_DATA;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WAIT_DATA: begin
        if (!busy_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef MAX10NIOS_BUSY_POLLER_TIMEOUT_EN
        else if (poll_count_q == 16'(MAX_POLLS)) begin
          timed_out_d = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
        else begin
          gap_load_s = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_zero_s) begin
          state_d = ST_READ;
        end else begin
          gap_dec_s = 1'b1;
          state_d   = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Strobes are registered from the next state so they change on the edge.
    avm_read_d = (state_d == ST_READ);
    active_d   = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      poll_count_q <= 16'd0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      active_q     <= 1'b0;
      avm_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      poll_count_q <= poll_count_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      active_q     <= active_d;
      avm_read_q   <= avm_read_d;
    end
  end

  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign active      = active_q;
  assign poll_count  = poll_count_q;
  assign avm_read    = avm_read_q;
  assign avm_address = STATUS_ADDR;

  // Only the busy bit of the status word matters; fold the rest away.
  logic unused_s;
`ifdef MAX10NIOS_BUSY_POLLER_TIMEOUT_EN
  assign unused_s = ^avm_readdata;
`else
  assign unused_s = ^{avm_readdata, 16'(MAX_POLLS)};
`endif

endmodule

// File: tb/tb_max10nios_busy_poller.sv
// -----------------------------------------------------------------------------
// tb_max10nios_busy_poller
// Randomized bench for max10nios_busy_poller. A slave model drives random
// stalls and random status words; an operation-level model predicts the
// number of reads, the completion cycle and the kind of pulse from the poll
// rules (read + stalls + data cycle per poll, POLL_GAP between polls).
// -----------------------------------------------------------------------------
module tb_max10nios_busy_poller;

  localparam int POLL_GAP  = 4;
  localparam int MAX_POLLS = 8;
  localparam int BUSY_BIT  = 5;
  localparam int LIMIT     = 1000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic        timed_out;
  logic        active;
  logic [15:0] poll_count;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int vectors;
  int miscompares;

  max10nios_busy_poller #(
    .POLL_GAP  (POLL_GAP),
    .MAX_POLLS (MAX_POLLS),
    .BUSY_BIT  (BUSY_BIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .done            (done),
    .timed_out       (timed_out),
    .active          (active),
    .poll_count      (poll_count),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] status_word(input bit busy);
    logic [31:0] mask;
    mask = 32'd1 << BUSY_BIT;
    return ($urandom & ~mask) | (busy ? mask : 32'd0);
  endfunction

  // One complete operation: nb busy polls followed by a clear one.
  task automatic run_op(input int nb, input int max_stall, input int first_stall);
    int  stalls[64];
    int  polls;
    int  expect_to;
    int  exp_cycle;
    int  acc_cnt;
    int  stall_left;
    bit  acc_last;
    bit  prev_stall;
    bit  finished;
    int  k;

    for (int i = 0; i < 64; i++) stalls[i] = $urandom_range(0, max_stall);
    if (first_stall >= 0) stalls[0] = first_stall;

    expect_to = 0;
    polls     = nb + 1;
`ifdef MAX10NIOS_BUSY_POLLER_TIMEOUT_EN
    if (nb >= MAX_POLLS) begin
      expect_to = 1;
      polls     = MAX_POLLS;
    end
`endif
    exp_cycle = 1 + (polls - 1) * POLL_GAP;
    for (int i = 0; i < polls; i++) exp_cycle += stalls[i] + 2;

    start = 1'b1;
    avm_waitrequest = 1'($urandom_range(0, 1));
    avm_readdata = $urandom;
    tick();
    start = 1'b0;

    acc_cnt    = 0;
    stall_left = stalls[0];
    acc_last   = 1'b0;
    prev_stall = 1'b0;
    finished   = 1'b0;
    k          = 1;
    while (!finished && k <= LIMIT) begin
      if (k == 1) begin
        check_eq("poll_count_cleared", 32'(poll_count), 32'd0);
        check_eq("active_after_start", 32'(active), 32'd1);
      end
      if (prev_stall) check_eq("read_held_in_stall", 32'(avm_read), 32'd1);
      if (avm_read) check_eq("address_zero", 32'(avm_address), 32'd0);

      if (acc_last) avm_readdata = status_word(acc_cnt <= nb);
      else          avm_readdata = $urandom;
      if (avm_read && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else if (avm_read) begin
        avm_waitrequest = 1'b0;
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1));
      end

      if (done || timed_out) begin
        finished = 1'b1;
        check_eq("end_cycle", 32'(k), 32'(exp_cycle));
        check_eq("done_flag", 32'(done), 32'(!expect_to));
        check_eq("timed_out_flag", 32'(timed_out), 32'(expect_to));
        check_eq("reads_issued", 32'(acc_cnt), 32'(polls));
        check_eq("poll_count_end", 32'(poll_count), 32'(polls));
        check_eq("active_in_pulse", 32'(active), 32'd0);
        // A start coinciding with the pulse must be dropped.
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check_eq("pulse_one_cycle", 32'({done, timed_out}), 32'd0);
        check_eq("start_in_pulse_ignored", 32'(active), 32'd0);
        check_eq("poll_count_kept", 32'(poll_count), 32'(polls));
      end else begin
        // Starts while busy are ignored; the model does not react to them.
        start = active ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        prev_stall = avm_read && avm_waitrequest;
        acc_last   = avm_read && !avm_waitrequest;
        if (acc_last) begin
          acc_cnt++;
          stall_left = stalls[acc_cnt];
        end
        tick();
        k++;
      end
    end
    start = 1'b0;
    if (!finished) check_eq("op_timeout_bound", 32'(k), 32'(exp_cycle));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata = $urandom;
      tick();
      check_eq("idle_quiet", 32'({done, timed_out, active, avm_read}), 32'd0);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    #2;
    check_eq("reset_outputs",
             32'({done, timed_out, active, avm_read, avm_address}), 32'd0);
    check_eq("reset_poll_count", 32'(poll_count), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    idle_cycles(2);

    // Busy clear at once, no stall: done on the 3rd cycle, one read.
    run_op(0, 0, -1);
    // Three busy polls then clear, no stalls.
    run_op(3, 0, -1);
    // Five-cycle stall on the first read.
    run_op(0, 0, 5);
    // Busy stuck past MAX_POLLS: timeout build stops at 8, else runs on.
    run_op(12, 1, -1);
    idle_cycles(1);

    // Reset in WAIT_DATA while the sampled busy bit is clear.
    start = 1'b1;
    tick();
    start = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    check_eq("reset_test_in_wait", 32'({avm_read, active}), 32'b01);
    avm_readdata = status_word(1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_eq("reset_async_outputs",
             32'({done, timed_out, active, avm_read, avm_address}), 32'd0);
    check_eq("reset_async_poll_count", 32'(poll_count), 32'd0);
    tick();
    reset = 1'b0;
    idle_cycles(4);
    run_op(1, 2, -1);

    // Randomized operations with random idle spacing (possibly zero).
    for (int n = 0; n < 25; n++) begin
      run_op($urandom_range(0, 10), 3, -1);
      idle_cycles($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
